// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//   Arbitrates two requesters onto a single-port-per-direction synchronous RAM.
//   One access is handled at a time by a four-state FSM (IDLE/WRITE/READ/RESP).
//   The winner's We/Addr/WData are captured in IDLE; writes take 2 cycles and
//   reads take 3 cycles (the RAM returns data one cycle after RamOutSel).
//
// Configuration macro:
//   RAM_ARB_FIXED_PRIO_EN  defined   -> Req0 always wins contention.
//                          undefined -> round-robin using a 1-bit LastGnt.
//
// Ports:
//   Clk, ResetN            clock, synchronous active-low reset
//   Req0/1, We0/1          requests and write/read select (held until Gnt)
//   Addr0/1, WData0/1      request address and write data (held until Gnt)
//   Gnt0/1                 one-cycle pulse when the RAM access is issued
//   RValid0/1, RData       read response pulse and shared read data
//   RamInSel, RamIn, RamWe RAM write port
//   RamOutSel, RamOut      RAM read port (RamOut valid one cycle later)
//   Busy                   1 whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module ram_arbiter (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        We0,
  input  logic        We1,
  input  logic [7:0]  Addr0,
  input  logic [7:0]  Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        RValid0,
  output logic        RValid1,
  output logic [31:0] RData,
  output logic [7:0]  RamInSel,
  output logic [31:0] RamIn,
  output logic        RamWe,
  output logic [7:0]  RamOutSel,
  input  logic [31:0] RamOut,
  output logic        Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_win;
  logic        w_win_nxt;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic        r_last_gnt;
  logic        w_last_gnt_nxt;
`endif

  logic        r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_ram_we, r_busy;
  logic        w_gnt0_nxt, w_gnt1_nxt, w_rvalid0_nxt, w_rvalid1_nxt, w_ram_we_nxt;
  logic [7:0]  r_ram_in_sel, r_ram_out_sel;
  logic [7:0]  w_ram_in_sel_nxt, w_ram_out_sel_nxt;
  logic [31:0] r_ram_in, r_rdata;
  logic [31:0] w_ram_in_nxt, w_rdata_nxt;

  logic        w_pick;
  logic        w_sel_we;
  logic [7:0]  w_sel_addr;
  logic [31:0] w_sel_wdata;

  // Arbitration: choose the requester that wins if the FSM samples now
  always_comb begin
    w_pick = 1'b0;
    if (Req0 && Req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      w_pick = 1'b0;
`else
      // The requester that was not served last time wins.
      w_pick = ~r_last_gnt;
`endif
    end else if (Req1) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
  end

  assign w_sel_we    = w_pick ? We1    : We0;
  assign w_sel_addr  = w_pick ? Addr1  : Addr0;
  assign w_sel_wdata = w_pick ? WData1 : WData0;

  // FSM next state and next values of all registered outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_win_nxt         = r_win;
`ifndef RAM_ARB_FIXED_PRIO_EN
    w_last_gnt_nxt    = r_last_gnt;
`endif
    w_gnt0_nxt        = 1'b0;
    w_gnt1_nxt        = 1'b0;
    w_rvalid0_nxt     = 1'b0;
    w_rvalid1_nxt     = 1'b0;
    w_ram_we_nxt      = 1'b0;
    w_ram_in_sel_nxt  = r_ram_in_sel;
    w_ram_in_nxt      = r_ram_in;
    w_ram_out_sel_nxt = r_ram_out_sel;
    w_rdata_nxt       = r_rdata;

    case (r_state)
      S_IDLE: begin
        if (Req0 || Req1) begin
          w_win_nxt  = w_pick;
`ifndef RAM_ARB_FIXED_PRIO_EN
          w_last_gnt_nxt = w_pick;
`endif
          w_gnt0_nxt = ~w_pick;
          w_gnt1_nxt = w_pick;
          // Only the port actually used is loaded; the other keeps its value.
          if (w_sel_we) begin
            w_state_nxt      = S_WRITE;
            w_ram_we_nxt     = 1'b1;
            w_ram_in_sel_nxt = w_sel_addr;
            w_ram_in_nxt     = w_sel_wdata;
          end else begin
            w_state_nxt       = S_READ;
            w_ram_out_sel_nxt = w_sel_addr;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
      end
      S_READ: begin
        // RamOut becomes valid in RESP, together with the RValid pulse.
        w_state_nxt   = S_RESP;
        w_rvalid0_nxt = ~r_win;
        w_rvalid1_nxt = r_win;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_rdata_nxt = RamOut;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output, winner and arbitration-history registers
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_win         <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      r_last_gnt    <= 1'b1;
`endif
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      r_ram_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_ram_in_sel  <= 8'h00;
      r_ram_in      <= 32'h0000_0000;
      r_ram_out_sel <= 8'h00;
      r_rdata       <= 32'h0000_0000;
    end else begin
      r_win         <= w_win_nxt;
`ifndef RAM_ARB_FIXED_PRIO_EN
      r_last_gnt    <= w_last_gnt_nxt;
`endif
      r_gnt0        <= w_gnt0_nxt;
      r_gnt1        <= w_gnt1_nxt;
      r_rvalid0     <= w_rvalid0_nxt;
      r_rvalid1     <= w_rvalid1_nxt;
      r_ram_we      <= w_ram_we_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_ram_in_sel  <= w_ram_in_sel_nxt;
      r_ram_in      <= w_ram_in_nxt;
      r_ram_out_sel <= w_ram_out_sel_nxt;
      r_rdata       <= w_rdata_nxt;
    end
  end

  assign Gnt0      = r_gnt0;
  assign Gnt1      = r_gnt1;
  assign RValid0   = r_rvalid0;
  assign RValid1   = r_rvalid1;
  assign RamWe     = r_ram_we;
  assign Busy      = r_busy;
  assign RamInSel  = r_ram_in_sel;
  assign RamIn     = r_ram_in;
  assign RamOutSel = r_ram_out_sel;
  // The RAM only delivers data during RESP, so RData passes RamOut through
  // in that cycle and afterwards holds the captured copy.
  assign RData     = (r_state == S_RESP) ? RamOut : r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//   Scoreboard bench for ram_arbiter. A transaction-level model predicts the
//   service order, grant/response cycles and read data; a monitor compares
//   every Gnt/RValid pulse against the queued expectations.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
  logic [7:0]  Addr0 = 8'h00, Addr1 = 8'h00;
  logic [31:0] WData0 = 32'h0, WData1 = 32'h0;
  logic        Gnt0, Gnt1, RValid0, RValid1, RamWe, Busy;
  logic [31:0] RData, RamIn;
  logic [7:0]  RamInSel, RamOutSel;
  logic [31:0] RamOut = 32'h0;

  always #5 Clk = ~Clk;

  ram_arbiter dut (
    .Clk(Clk), .ResetN(ResetN),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
    .RData(RData), .RamInSel(RamInSel), .RamIn(RamIn), .RamWe(RamWe),
    .RamOutSel(RamOutSel), .RamOut(RamOut), .Busy(Busy)
  );

  typedef struct {
    logic        who;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    int          gcyc;
    int          rcyc;
  } gexp_t;

  typedef struct {
    logic        who;
    logic [31:0] data;
    int          rcyc;
  } rexp_t;

  gexp_t       gq[$];
  rexp_t       rq[$];
  gexp_t       mon_g;
  rexp_t       mon_r;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        m_last = 1'b1;
  logic [31:0] m_mem [256];
  logic [31:0] ram [256];
  logic        ram_ready = 1'b0;

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural RAM: synchronous write, one-cycle read latency
  always @(posedge Clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= seed(i);
      ram_ready <= 1'b1;
    end else begin
      if (RamWe) ram[RamInSel] <= RamIn;
      RamOut <= ram[RamOutSel];
    end
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compare every grant / response pulse with the scoreboard
  always @(negedge Clk) begin
    if (Gnt0 || Gnt1) begin
      chk("gnt_onehot", 32'(Gnt0 & Gnt1), 32'd0);
      if (gq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL gnt_unexpected actual=Gnt0:%0b,Gnt1:%0b required=no grant", Gnt0, Gnt1);
      end else begin
        mon_g = gq.pop_front();
        chk("gnt_who", 32'(Gnt1), 32'(mon_g.who));
        chk("gnt_cycle", 32'(cyc), 32'(mon_g.gcyc));
        chk("gnt_busy", 32'(Busy), 32'd1);
        chk("gnt_ramwe", 32'(RamWe), 32'(mon_g.we));
        if (mon_g.we) begin
          chk("wr_addr", 32'(RamInSel), 32'(mon_g.addr));
          chk("wr_data", RamIn, mon_g.data);
        end else begin
          chk("rd_addr", 32'(RamOutSel), 32'(mon_g.addr));
          mon_r.who  = mon_g.who;
          mon_r.data = mon_g.data;
          mon_r.rcyc = mon_g.rcyc;
          rq.push_back(mon_r);
        end
      end
    end else if (RamWe) begin
      n_cmp++; n_err++;
      $display("FAIL ramwe_stray actual=1 required=0 (cycle %0d)", cyc);
    end
    if (RValid0 || RValid1) begin
      chk("rv_onehot", 32'(RValid0 & RValid1), 32'd0);
      if (rq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rv_unexpected actual=RValid0:%0b,RValid1:%0b required=none", RValid0, RValid1);
      end else begin
        mon_r = rq.pop_front();
        chk("rv_who", 32'(RValid1), 32'(mon_r.who));
        chk("rv_cycle", 32'(cyc), 32'(mon_r.rcyc));
        chk("rv_data", RData, mon_r.data);
      end
    end
  end

  // Reference arbitration rule on the set of still-pending requesters
  function automatic logic choose(input logic p0, input logic p1);
    if (p0 && p1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~m_last;
`endif
    end
    return p0 ? 1'b0 : 1'b1;
  endfunction

  // Issue requests (caller is at negedge+1 with the DUT idle), predict the
  // n grants, then wait for the scoreboard to drain. hold=1 keeps Req high.
  task automatic run_round(input logic r0, input logic r1, input logic we0i, input logic we1i,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int n, input logic hold);
    gexp_t e;
    logic  p0 = r0, p1 = r1, w;
    int    t = cyc;
    int    g_seen = 0;
    logic  done = 1'b0;
    Req0 = r0; We0 = we0i; Addr0 = a0; WData0 = d0;
    Req1 = r1; We1 = we1i; Addr1 = a1; WData1 = d1;
    for (int k = 0; k < n; k++) begin
      w = choose(p0, p1);
      m_last = w;
      e.who  = w;
      e.we   = w ? we1i : we0i;
      e.addr = w ? a1 : a0;
      e.gcyc = t + 1;
      e.rcyc = t + 2;
      if (e.we) begin
        e.data = w ? d1 : d0;
        m_mem[e.addr] = e.data;
        t += 2;
      end else begin
        e.data = m_mem[e.addr];
        t += 3;
      end
      gq.push_back(e);
      if (!hold) begin
        if (w) p1 = 1'b0; else p0 = 1'b0;
      end
    end
    for (int cy = 0; cy < 8 * n + 10 && !done; cy++) begin
      @(negedge Clk); #1;
      if (Gnt0 || Gnt1) begin
        g_seen++;
        if (!hold) begin
          if (Gnt0) Req0 = 1'b0;
          if (Gnt1) Req1 = 1'b0;
        end
      end
      if (hold && g_seen >= n) begin
        Req0 = 1'b0; Req1 = 1'b0;
      end
      // Fields of a requester that is not requesting may change freely.
      if (!Req0) begin We0 = 1'($urandom); Addr0 = 8'($urandom); WData0 = $urandom; end
      if (!Req1) begin We1 = 1'($urandom); Addr1 = 8'($urandom); WData1 = $urandom; end
      done = (gq.size() == 0) && (rq.size() == 0) && !Req0 && !Req1;
    end
    chk("round_done", 32'(done), 32'd1);
    if (!done) begin
      gq.delete(); rq.delete(); Req0 = 1'b0; Req1 = 1'b0;
    end
    @(negedge Clk); #1;
    chk("busy_after", 32'(Busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_gnt0"}, 32'(Gnt0), 32'd0);
    chk({tag, "_gnt1"}, 32'(Gnt1), 32'd0);
    chk({tag, "_rv0"}, 32'(RValid0), 32'd0);
    chk({tag, "_rv1"}, 32'(RValid1), 32'd0);
    chk({tag, "_ramwe"}, 32'(RamWe), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_insel"}, 32'(RamInSel), 32'd0);
    chk({tag, "_outsel"}, 32'(RamOutSel), 32'd0);
    chk({tag, "_ramin"}, RamIn, 32'd0);
    chk({tag, "_rdata"}, RData, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    gexp_t e;
    for (int i = 0; i < 256; i++) m_mem[i] = seed(i);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_values("reset");
    ResetN = 1'b1;
    @(negedge Clk); #1;

    // Single write, then single read of the same word by the other requester
    run_round(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0, 1, 1'b0);
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 32'h0, 32'h0, 1, 1'b0);

    // Continuous contention, both writing
    run_round(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h21, $urandom, $urandom, 6, 1'b1);

    // Reset in the READ state abandons the access (requester 0 read leaves LastGnt=0)
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 8'h33;
    e.who = 1'b0; e.we = 1'b0; e.addr = 8'h33; e.data = m_mem[8'h33];
    e.gcyc = cyc + 1; e.rcyc = cyc + 2;
    gq.push_back(e);
    @(posedge Clk); #1;
    Req0 = 1'b0;
    ResetN = 1'b0;
    @(negedge Clk); #1;
    chk("rst_gnt_seen", 32'(gq.size()), 32'd0);
    rq.delete();
    @(negedge Clk);
    check_reset_values("midrst");
    ResetN = 1'b1;
    m_last = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    run_round(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h41, 32'h0, $urandom, 2, 1'b0);

    // Address sweep: 32 writes then 32 reads by requester 0
    for (int k = 0; k < 32; k++)
      run_round(1'b1, 1'b0, 1'b1, 1'b0, 8'(8 * k), 8'h00, 32'(2048 * k), 32'h0, 1, 1'b0);
    for (int k = 0; k < 32; k++)
      run_round(1'b1, 1'b0, 1'b0, 1'b0, 8'(8 * k), 8'h00, 32'h0, 32'h0, 1, 1'b0);

    // Randomised traffic
    for (int r = 0; r < 60; r++) begin
      int m = $urandom_range(1, 3);
      logic q0 = m[0];
      logic q1 = m[1];
      run_round(q0, q1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                $urandom, $urandom, int'(q0) + int'(q1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, port list ordered as follows.
REQ-002 Clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 ResetN  input  1  synchronous active-low reset, sampled on the rising edge of Clk.
REQ-004 Req0, Req1  input  1 each  access request from requester 0 and requester 1.
REQ-005 We0, We1  input  1 each  1 = write, 0 = read; held with Req until granted.
REQ-006 Addr0, Addr1  input  8 each  RAM word address; held with Req until granted.
REQ-007 WData0, WData1  input  32 each  write data; held with Req until granted.
REQ-008 Gnt0, Gnt1  output  1 each  one-cycle pulse in the cycle the RAM access is issued.
REQ-009 RValid0, RValid1  output  1 each  one-cycle pulse; RData holds read data for that requester.
REQ-010 RData  output  32  read data, shared by both requesters, qualified by RValid0/RValid1.
REQ-011 RamInSel  output  8  RAM write address.
REQ-012 RamIn  output  32  RAM write data.
REQ-013 RamWe  output  1  RAM write enable; the RAM writes only when it is 1.
REQ-014 RamOutSel  output  8  RAM read address.
REQ-015 RamOut  input  32  RAM read data, valid one Clk cycle after RamOutSel is presented.
REQ-016 Busy  output  1  1 in any state other than IDLE.

Function
REQ-017 FSM states SHALL be: IDLE, WRITE, READ, RESP.
REQ-018 IDLE: if any Req is set, the FSM SHALL select a winner and latch its We, Addr and WData.
- Next state SHALL be WRITE if the latched We is 1, otherwise READ.
- With no Req set, the FSM SHALL stay in IDLE.
REQ-019 WRITE: RamWe=1, RamInSel=latched Addr, RamIn=latched WData, and the winner's Gnt=1 for exactly one cycle; next state SHALL be IDLE.
REQ-020 READ: RamOutSel=latched Addr and the winner's Gnt=1 for exactly one cycle; next state SHALL be RESP.
REQ-021 RESP: RData=RamOut and the winner's RValid=1 for exactly one cycle; next state SHALL be IDLE.
REQ-022 Latency from Req sampled in IDLE: write Gnt at +1 cycle; read Gnt at +1 cycle; read RValid at +2 cycles.
REQ-023 Throughput: one write per 2 cycles; one read per 3 cycles.
REQ-024 Arbitration SHALL be round-robin using a 1-bit LastGnt register.
- Only one Req set: that requester wins.
- Both Req set: the requester not equal to LastGnt wins.
- LastGnt SHALL update to the winner when it is latched in IDLE.
REQ-025 Gnt0 and Gnt1 SHALL never both be 1; RValid0 and RValid1 SHALL never both be 1.
REQ-026 Req, We, Addr and WData changes in any state other than IDLE SHALL be ignored.
REQ-027 Once latched, an access SHALL complete even if its Req drops.
REQ-028 A requester that keeps Req high after Gnt SHALL be treated as a new request at the next IDLE.
REQ-029 RamWe SHALL be 0 in every state except WRITE.
REQ-030 RamInSel, RamIn and RamOutSel SHALL hold their last driven values when not in use.
REQ-031 All address arithmetic SHALL be 8-bit with no translation; addresses 0x00-0xFF are all valid.

Reset
REQ-032 With ResetN=0 at a rising edge, the block SHALL set:
- state=IDLE, LastGnt=1, so requester 0 wins the first contention;
- Gnt0/Gnt1/RValid0/RValid1/RamWe/Busy=0;
- RamInSel/RamOutSel=8'h00, RamIn/RData=32'h0.
REQ-033 Reset asserted mid-operation SHALL abandon the in-flight access.
- No Gnt or RValid SHALL be issued for it.
- RamWe SHALL be 0 from the first reset edge onward.

Configuration
REQ-034 Macro RAM_ARB_FIXED_PRIO_EN SHALL select the arbitration scheme.
- Defined: Req0 SHALL always win contention, and LastGnt is unused.
- Undefined (default): round-robin per REQ-024.

Verification
REQ-035 Single write: Req0=1, We0=1, Addr0=8'h10, WData0=32'hDEADBEEF -> Gnt0, RamWe=1, RamInSel=8'h10, RamIn=32'hDEADBEEF at +1 cycle; Busy for 1 cycle.
REQ-036 Single read: RAM[8'h10]=32'hDEADBEEF; Req1=1, We1=0, Addr1=8'h10 -> Gnt1 at +1; RValid1=1 and RData=32'hDEADBEEF at +2.
REQ-037 Contention: Req0 and Req1 held high continuously, both writes -> grants alternate Gnt0, Gnt1, Gnt0... starting with Gnt0 (fixed-priority build: Gnt0 only).
REQ-038 Reset mid-read: ResetN=0 in the READ state -> no RValid pulse, outputs at reset values, first grant after release goes to Req0.
REQ-039 Address sweep: requester 0 writes WData=32'd2048*k to Addr=8*k for k=0..31, then reads all 32 -> each RValid0 returns 32'd2048*k; Addr=8'hF8 is the last access with no wrap error.
